// File: rtl/cic_interp.sv
// Integer-ratio CIC interpolator: low-rate comb section, zero-stuffing,
// high-rate integrator section, then shift and saturate.
module cic_interp #(
    parameter int DATA_WIDTH_I        = 16,
    parameter int DATA_WIDTH_O        = 12,
    parameter int REGISTER_WIDTH      = 56,
    parameter int INTERPOLATION_RATIO = 1625,
    parameter int STAGES              = 3,
    parameter int OUT_SHIFT           = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic [DATA_WIDTH_I-1:0] filter_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH_O-1:0] filter_out,
    output logic                    ce_out,
    output logic                    underrun
);

    localparam int PW = $clog2(INTERPOLATION_RATIO);

    typedef logic signed [REGISTER_WIDTH-1:0] reg_t;

    localparam reg_t MAXV = (reg_t'(1) <<< (DATA_WIDTH_O - 1)) - reg_t'(1);
    localparam reg_t MINV = -(reg_t'(1) <<< (DATA_WIDTH_O - 1));

    logic [PW-1:0] phase;
    reg_t          d     [STAGES];
    reg_t          c     [STAGES+1];
    reg_t          integ [STAGES];
    reg_t          z;
    reg_t          s;
    logic [DATA_WIDTH_O-1:0] sat;

    assign in_ready = (phase == '0);

    // Comb chain is only consumed on the slot tick; an empty slot feeds 0.
    always_comb begin
        c[0] = in_valid ? reg_t'($signed(filter_in)) : '0;
        for (int k = 1; k <= STAGES; k++) begin
            c[k] = c[k-1] - d[k-1];
        end
    end

    always_comb begin
        s   = integ[STAGES-1] >>> OUT_SHIFT;
        sat = s[DATA_WIDTH_O-1:0];
        if (s > MAXV) begin
            sat = MAXV[DATA_WIDTH_O-1:0];
        end else if (s < MINV) begin
            sat = MINV[DATA_WIDTH_O-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= '0;
            z          <= '0;
            filter_out <= '0;
            ce_out     <= 1'b0;
            underrun   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                d[k]     <= '0;
                integ[k] <= '0;
            end
        end else begin
            ce_out <= clk_enable;
            if (clk_enable) begin
                if (phase == PW'(INTERPOLATION_RATIO - 1)) begin
                    phase <= '0;
                end else begin
                    phase <= phase + PW'(1);
                end
                if (phase == '0) begin
                    for (int k = 0; k < STAGES; k++) begin
                        d[k] <= c[k];
                    end
                    z <= c[STAGES];
                    if (!in_valid) begin
                        underrun <= 1'b1;
                    end
                end else begin
                    z <= '0;
                end
                // Integrators wrap modulo 2^REGISTER_WIDTH by design.
                integ[0] <= integ[0] + z;
                for (int j = 1; j < STAGES; j++) begin
                    integ[j] <= integ[j] + integ[j-1];
                end
                filter_out <= sat;
            end
        end
    end

endmodule

// File: tb/tb_cic_interp.sv
// Scoreboard bench for cic_interp: two R=4, N=3 instances (shift 0 / 12-bit
// output and shift 4 / 16-bit output) driven by the same directed stimulus.
module tb_cic_interp;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [15:0] filter_in;
    logic        in_valid;
    logic        in_ready_a, in_ready_b;
    logic [11:0] filter_out_a;
    logic [15:0] filter_out_b;
    logic        ce_out_a, ce_out_b;
    logic        underrun_a, underrun_b;

    int checks   = 0;
    int failures = 0;

    int h [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    int xs [$];
    int qa [$];
    int qb [$];
    int n_tick    = 0;
    int tot_ticks = 0;
    int n_ce      = 0;
    bit exp_under = 0;
    bit mon_en    = 0;

    always #5 clk = ~clk;

    cic_interp #(
        .DATA_WIDTH_I(16), .DATA_WIDTH_O(12), .REGISTER_WIDTH(56),
        .INTERPOLATION_RATIO(4), .STAGES(3), .OUT_SHIFT(0)
    ) dut_a (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .filter_in(filter_in), .in_valid(in_valid), .in_ready(in_ready_a),
        .filter_out(filter_out_a), .ce_out(ce_out_a), .underrun(underrun_a)
    );

    cic_interp #(
        .DATA_WIDTH_I(16), .DATA_WIDTH_O(16), .REGISTER_WIDTH(56),
        .INTERPOLATION_RATIO(4), .STAGES(3), .OUT_SHIFT(4)
    ) dut_b (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .filter_in(filter_in), .in_valid(in_valid), .in_ready(in_ready_b),
        .filter_out(filter_out_b), .ce_out(ce_out_b), .underrun(underrun_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected output after high-rate tick nn: convolution of slot samples
    // with the (1+z^-1+z^-2+z^-3)^3 kernel, delayed by N+1 ticks.
    function automatic int model_out(int nn, int sh, int lo, int hi);
        int m;
        int y;
        int p;
        m = nn - 4;
        y = 0;
        for (int k = 0; k < xs.size(); k++) begin
            p = m - 4 * k;
            if (p >= 0 && p < 10) y += xs[k] * h[p];
        end
        y = y >>> sh;
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return y;
    endfunction

    task automatic tick(input bit v, input int d, input int gap);
        in_valid   = v;
        filter_in  = d[15:0];
        clk_enable = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        clk_enable = 1'b1;
        chk("in_ready_a", int'(in_ready_a), int'(n_tick % 4 == 0));
        chk("in_ready_b", int'(in_ready_b), int'(n_tick % 4 == 0));
        if (n_tick % 4 == 0) begin
            xs.push_back(v ? d : 0);
            if (!v) exp_under = 1;
        end
        qa.push_back(model_out(n_tick, 0, -2048, 2047));
        qb.push_back(model_out(n_tick, 4, -32768, 32767));
        n_tick++;
        tot_ticks++;
        @(posedge clk);
        #1;
        clk_enable = 1'b0;
        chk("underrun", int'(underrun_a), int'(exp_under));
    endtask

    // One input frame: a slot tick then R-1 ticks with junk on the bus.
    task automatic frame(input bit v, input int d, input int gap);
        tick(v, d, gap);
        repeat (3) tick(1'b1, 12345, gap);
    endtask

    task automatic do_reset(input bit ce);
        reset      = 1'b1;
        clk_enable = ce;
        in_valid   = 1'b1;
        filter_in  = 16'd77;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        clk_enable = 1'b0;
        xs.delete();
        qa.delete();
        qb.delete();
        n_tick    = 0;
        exp_under = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ce_out_a !== ce_out_b) begin
                chk("ce_out_match", int'(ce_out_b), int'(ce_out_a));
            end
            if (ce_out_a === 1'b1) begin
                n_ce++;
                if (qa.size() == 0 || qb.size() == 0) begin
                    chk("ce_unexpected", 1, 0);
                end else begin
                    chk("out_a", int'($signed(filter_out_a)), qa.pop_front());
                    chk("out_b", int'($signed(filter_out_b)), qb.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        clk_enable = 1'b0;
        in_valid   = 1'b0;
        filter_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;
        do_reset(1'b0);

        // Idle after reset: nothing moves.
        repeat (3) begin
            chk("rst_out", int'($signed(filter_out_a)), 0);
            chk("rst_ce", int'(ce_out_a), 0);
            chk("rst_ready", int'(in_ready_a), 1);
            chk("rst_under", int'(underrun_a), 0);
            @(posedge clk);
            #1;
        end

        // Impulse response 1,3,6,10,12,12,10,6,3,1.
        frame(1'b1, 1, 0);
        repeat (4) frame(1'b1, 0, 0);

        // DC 100: gain 16.
        repeat (6) frame(1'b1, 100, 0);
        chk("dc_a", int'($signed(filter_out_a)), 1600);
        chk("dc_b", int'($signed(filter_out_b)), 100);

        // Saturation both ways.
        repeat (6) frame(1'b1, 1000, 0);
        chk("sat_pos_a", int'($signed(filter_out_a)), 2047);
        chk("sat_pos_b", int'($signed(filter_out_b)), 1000);
        repeat (6) frame(1'b1, -1000, 0);
        chk("sat_neg_a", int'($signed(filter_out_a)), -2048);
        chk("sat_neg_b", int'($signed(filter_out_b)), -1000);
        repeat (4) frame(1'b1, 0, 0);

        // Sparse ticks with one empty slot.
        repeat (2) frame(1'b1, 200, 2);
        chk("under_pre", int'(underrun_b), 0);
        frame(1'b0, 200, 2);
        chk("under_set", int'(underrun_b), 1);
        repeat (2) frame(1'b1, 200, 2);
        repeat (4) frame(1'b1, 0, 2);
        chk("under_sticky", int'(underrun_b), 1);

        // Reset at phase 2 with live state, then the impulse again.
        frame(1'b1, 1, 0);
        tick(1'b1, 12345, 0);
        tick(1'b1, 12345, 0);
        chk("pre_rst_out", int'($signed(filter_out_a)), 3);
        do_reset(1'b1);
        chk("mid_rst_out", int'($signed(filter_out_a)), 0);
        chk("mid_rst_ce", int'(ce_out_a), 0);
        chk("mid_rst_ready", int'(in_ready_a), 1);
        chk("mid_rst_under", int'(underrun_a), 0);
        frame(1'b1, 1, 0);
        repeat (4) frame(1'b1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("ce_count", n_ce, tot_ticks);
        chk("queue_empty", qa.size() + qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
